sync_fifo: RTL
==============

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DLY, default 1, simulation delay on register assignments.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, width of each entry.
REQ-003 SHALL have parameter FIFO_DEPTH, default 32, number of entries; power of 2, >= 4.
REQ-004 SHALL have parameter FWFT, default 0, read mode (0 = standard, 1 = first-word-fall-through).
REQ-005 SHALL have parameter AFULL_THRESH, default FIFO_DEPTH-2, almost-full level.
REQ-006 SHALL have parameter AEMPTY_THRESH, default 2, almost-empty level.
REQ-007 SHALL have port clk_i, input, 1, single clock; all logic rising-edge.
REQ-008 SHALL have port rst_i, input, 1, reset; asynchronous, active-high.
REQ-009 SHALL have port wr_en_i, input, 1, write request.
REQ-010 SHALL have port wr_data_i, input, DATA_WIDTH, write data.
REQ-011 SHALL have port rd_en_i, input, 1, read request (pop in FWFT).
REQ-012 SHALL have port rd_data_o, output, DATA_WIDTH, read data.
REQ-013 SHALL have port rd_valid_o, output, 1, rd_data_o qualifier.
REQ-014 SHALL have port full_o / afull_o / empty_o / aempty_o, output, 1 each, status.
REQ-015 SHALL have port overflow_o / underflow_o, output, 1 each, error pulses.
REQ-016 SHALL have port data_cnt_o, output, $clog2(FIFO_DEPTH)+1, occupancy.

Function
REQ-017 SHALL accept a write only when wr_en_i=1 and full_o=0; the entry is stored at wr_ptr and wr_ptr increments, wrapping modulo FIFO_DEPTH.
REQ-018 SHALL accept a read only when rd_en_i=1 and empty_o=0; rd_ptr increments, wrapping modulo FIFO_DEPTH.
REQ-019 SHALL update the count each accepted cycle: +1 write only, -1 read only, unchanged for both or neither; data_cnt_o equals the count register.
REQ-020 SHALL drive full_o = (count==FIFO_DEPTH), empty_o = (count==0), afull_o = (count>=AFULL_THRESH), aempty_o = (count<=AEMPTY_THRESH), all decoded from registers only.
REQ-021 SHALL, when full, reject a write even if a read is accepted in the same cycle; the read still proceeds.
REQ-022 SHALL, when empty, reject a read even if a write is accepted in the same cycle (no bypass); the write still proceeds.
REQ-023 SHALL, with FWFT=0, register mem[rd_ptr] into rd_data_o on an accepted read and assert rd_valid_o for exactly the following cycle; rd_data_o holds its value otherwise.
REQ-024 SHALL, with FWFT=1, present the head entry on rd_data_o combinationally with rd_valid_o = !empty_o; an accepted read advances to the next entry next cycle.
REQ-025 SHALL, with FWFT=1, present a word written into an empty FIFO with rd_valid_o=1 in the cycle after the write edge.
REQ-026 SHALL pulse overflow_o for one cycle, the cycle after wr_en_i=1 with full_o=1; contents are unchanged.
REQ-027 SHALL pulse underflow_o for one cycle, the cycle after rd_en_i=1 with empty_o=1; pointers are unchanged.
REQ-028 SHALL have write-to-empty_o-deassert latency of 1 cycle and read-to-full_o-deassert latency of 1 cycle in both modes.

Reset
REQ-029 SHALL, on rst_i=1 and independent of clk_i, clear wr_ptr, rd_ptr and count to 0, rd_data_o to 0, and rd_valid_o, overflow_o, underflow_o to 0.
REQ-030 SHALL, during and after reset, drive empty_o=1, aempty_o=1, full_o=0, afull_o=0, data_cnt_o=0.
REQ-031 SHALL, on reset mid-operation, discard all stored entries; memory contents are not cleared and are never visible until rewritten.

Verification (DATA_WIDTH=8, FIFO_DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=2)
REQ-032 SHALL cover: FWFT=0, write 0x11,0x22,0x33, then read 3 cycles -> rd_valid_o high for 3 cycles, each one cycle after its read, carrying 0x11,0x22,0x33; empty_o=1 after the third read.
REQ-033 SHALL cover: write 8 words, then a 9th -> full_o=1 and data_cnt_o=8; overflow_o pulses once; read-back returns the original 8 words.
REQ-034 SHALL cover: at count=8, assert wr_en_i and rd_en_i together -> read accepted, write dropped, data_cnt_o=7; at count=0, assert both together -> write accepted, underflow_o pulses, data_cnt_o=1.
REQ-035 SHALL cover: FWFT=1, write 0xA5 into an empty FIFO -> next cycle rd_valid_o=1 and rd_data_o=0xA5 without rd_en_i; pop -> empty_o=1.
REQ-036 SHALL cover: fill to 5 entries, assert rst_i asynchronously mid-cycle -> data_cnt_o=0 and empty_o=1 immediately; subsequent write 0x5A reads back as 0x5A.
REQ-037 SHALL cover: 20 writes interleaved with 20 reads at count near 6 -> pointers wrap; afull_o tracks count>=6 and aempty_o tracks count<=2 every cycle; data order is preserved.

Source files
------------

// File: rtl/sync_fifo_if.sv
// Handshake bundle for sync_fifo: write/read requests, read data,
// status flags and occupancy.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  wr_en_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  rd_en_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  rd_valid_o;
  logic                  full_o;
  logic                  afull_o;
  logic                  empty_o;
  logic                  aempty_o;
  logic                  overflow_o;
  logic                  underflow_o;
  logic [CNT_W-1:0]      data_cnt_o;

  modport master (
    output wr_en_i, wr_data_i, rd_en_i,
    input  rd_data_o, rd_valid_o,
    input  full_o, afull_o, empty_o, aempty_o,
    input  overflow_o, underflow_o, data_cnt_o
  );

  modport slave (
    input  wr_en_i, wr_data_i, rd_en_i,
    output rd_data_o, rd_valid_o,
    output full_o, afull_o, empty_o, aempty_o,
    output overflow_o, underflow_o, data_cnt_o
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, standard or first-word-fall-through read,
// with almost-full/empty flags and overflow/underflow pulses.
module sync_fifo #(
  parameter int DLY           = 1,
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 32,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  sync_fifo_if.slave  bus_if
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // DLY only shapes simulation timing, so it is merely range-checked.
  if (DLY < 0 || FIFO_DEPTH < 4 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("sync_fifo: bad DLY or FIFO_DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, udf_q;

  logic full, empty;
  logic wr_acc, rd_acc;

  assign full   = (cnt_q == CW'(FIFO_DEPTH));
  assign empty  = (cnt_q == '0);
  assign wr_acc = bus_if.wr_en_i && !full;
  assign rd_acc = bus_if.rd_en_i && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case (1'b1)
      (wr_acc && !rd_acc): cnt_d = cnt_q + CW'(1);
      (rd_acc && !wr_acc): cnt_d = cnt_q - CW'(1);
      default:             cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= bus_if.wr_en_i && full;
      udf_q    <= bus_if.rd_en_i && empty;
    end
  end

  // Storage is never reset; the pointers alone decide visibility.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus_if.wr_data_i;
  end

  if (FWFT != 0) begin : g_fwft
    assign bus_if.rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign bus_if.rd_valid_o = !empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
      end
    end

    assign bus_if.rd_data_o  = rd_data_q;
    assign bus_if.rd_valid_o = rd_valid_q;
  end

  assign bus_if.full_o      = full;
  assign bus_if.empty_o     = empty;
  assign bus_if.afull_o     = (cnt_q >= CW'(AFULL_THRESH));
  assign bus_if.aempty_o    = (cnt_q <= CW'(AEMPTY_THRESH));
  assign bus_if.overflow_o  = ovf_q;
  assign bus_if.underflow_o = udf_q;
  assign bus_if.data_cnt_o  = cnt_q;
endmodule
